ir_queue: RTL and testbench

Parametrised instruction register with an integrated prefetch queue, sitting between instruction memory and the controller in the image-downsampling processor. Fetched instruction words enter through a valid/ready handshake and are buffered in a DEPTH-entry FIFO. The current instruction is held in an output register until the controller retires it with `advance`. The block also supplies a zero- or sign-extended immediate field, and supports a single-cycle `flush` for jumps and branches.

---
 rtl/ir_queue.sv | 114 +++++++++++
 tb/tb_ir_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO; supplies an extended
// immediate and clears the queue and the current instruction on a flush.
module ir_queue #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 4,
  parameter int IMM_WIDTH     = 4,
  parameter int IMM_OUT_WIDTH = 8,
  parameter int IMM_SIGNED    = 0
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [WIDTH-1:0]             ir_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         advance,
  input  logic                         flush,
  output logic [WIDTH-1:0]             ir_out,
  output logic                         ir_valid,
  output logic [IMM_OUT_WIDTH-1:0]     immediate,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ir_out_q, ir_out_d;
  logic             ir_valid_q, ir_valid_d;
  logic             accept, load, empty, push, pop;

  // Handshake: a word transfers on an edge where in_valid && in_ready. in_ready
  // depends only on occupancy and flush, never on advance, so a full queue
  // cannot pop and accept through in the same cycle.
  always_comb begin
    in_ready   = (count_q < CW'(DEPTH)) && !flush;
    accept     = in_valid && in_ready;
    load       = !ir_valid_q || advance;
    empty      = (count_q == '0);
    push       = 1'b0;
    pop        = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_out_d   = ir_out_q;
    ir_valid_d = ir_valid_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ir_out_d   = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (load) begin
        if (!empty) begin
          ir_out_d   = mem_q[rd_ptr_q];
          ir_valid_d = 1'b1;
          pop        = 1'b1;
          push       = accept;
        end else if (accept) begin
          // Empty queue: the incoming word goes straight to the register.
          ir_out_d   = ir_in;
          ir_valid_d = 1'b1;
        end else begin
          ir_valid_d = 1'b0;
        end
      end else begin
        push = accept;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ir_in;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_out_q   <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_out_q   <= ir_out_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign ir_out   = ir_out_q;
  assign ir_valid = ir_valid_q;
  assign count    = count_q;

  generate
    if (IMM_OUT_WIDTH == IMM_WIDTH) begin : g_imm_none
      assign immediate = ir_out_q[IMM_WIDTH-1:0];
    end else if (IMM_SIGNED != 0) begin : g_imm_sext
      assign immediate = {{(IMM_OUT_WIDTH-IMM_WIDTH){ir_out_q[IMM_WIDTH-1]}},
                          ir_out_q[IMM_WIDTH-1:0]};
    end else begin : g_imm_zext
      assign immediate = {{(IMM_OUT_WIDTH-IMM_WIDTH){1'b0}}, ir_out_q[IMM_WIDTH-1:0]};
    end
  endgenerate

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed vector table, hand sequences and random traffic
// checked against a queue-based model; a sign-extending copy shares the stimulus.
module tb_ir_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ir_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic       in_ready, in_ready_s;
  logic [7:0] ir_out, ir_out_s;
  logic       ir_valid, ir_valid_s;
  logic [7:0] imm, imm_s;
  logic [2:0] count, count_s;

  ir_queue #(.WIDTH(8), .DEPTH(DEPTH), .IMM_WIDTH(4), .IMM_OUT_WIDTH(8), .IMM_SIGNED(0)) dut (
    .clk(clk), .RST(rst), .ir_in(ir_in), .in_valid(in_valid), .in_ready(in_ready),
    .advance(advance), .flush(flush), .ir_out(ir_out), .ir_valid(ir_valid),
    .immediate(imm), .count(count)
  );

  ir_queue #(.WIDTH(8), .DEPTH(DEPTH), .IMM_WIDTH(4), .IMM_OUT_WIDTH(8), .IMM_SIGNED(1)) dut_s (
    .clk(clk), .RST(rst), .ir_in(ir_in), .in_valid(in_valid), .in_ready(in_ready_s),
    .advance(advance), .flush(flush), .ir_out(ir_out_s), .ir_valid(ir_valid_s),
    .immediate(imm_s), .count(count_s)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pending words in order, plus the current instruction
  logic [7:0] exp_q[$];
  logic [7:0] cur_m = 8'h00;
  logic       cv_m = 1'b0;
  logic       pre_rdy;

  typedef struct packed {
    logic       iv;
    logic [7:0] din;
    logic       adv;
    logic       fl;
    logic       rdy;
    logic [7:0] out;
    logic       vld;
    logic [2:0] cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic iv, input logic [7:0] d,
                            input logic a, input logic f);
    bit acc;
    if (r || f) begin
      exp_q.delete();
      cur_m = 8'h00;
      cv_m  = 1'b0;
    end else begin
      acc = iv && (exp_q.size() < DEPTH);
      if (!cv_m || a) begin
        if (exp_q.size() > 0) begin
          cur_m = exp_q.pop_front();
          cv_m  = 1'b1;
          if (acc) exp_q.push_back(d);
        end else if (acc) begin
          cur_m = d;
          cv_m  = 1'b1;
        end else begin
          cv_m = 1'b0;
        end
      end else if (acc) begin
        exp_q.push_back(d);
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] ez, es;
    ez = {4'h0, cur_m[3:0]};
    es = {{4{cur_m[3]}}, cur_m[3:0]};
    chk("ir_out", ir_out, cur_m);
    chk("ir_valid", ir_valid, cv_m);
    chk("count", 32'(count), exp_q.size());
    chk("immediate", imm, ez);
    chk("immediate_signed", imm_s, es);
    chk("ir_out_signed_copy", ir_out_s, cur_m);
  endtask

  // driver: inputs change at negedge, in_ready sampled before the edge,
  // outputs sampled 1 time unit after the rising edge
  task automatic cycle(input logic r, input logic iv, input logic [7:0] d,
                       input logic a, input logic f, input bit use_model);
    bit exp_rdy;
    @(negedge clk);
    rst = r; in_valid = iv; ir_in = d; advance = a; flush = f;
    #1;
    pre_rdy = in_ready;
    exp_rdy = (exp_q.size() < DEPTH) && !f;
    if (use_model && !r) chk("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    model_step(r, iv, d, a, f);
    #1;
    if (use_model) check_model();
  endtask

  task automatic add(input logic iv, input logic [7:0] din, input logic adv, input logic fl,
                     input logic rdy, input logic [7:0] out, input logic vld, input logic [2:0] cnt);
    vec_t v;
    v.iv = iv; v.din = din; v.adv = adv; v.fl = fl;
    v.rdy = rdy; v.out = out; v.vld = vld; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    // directed vectors: inputs, pre-edge in_ready, post-edge ir_out/ir_valid/count
    add(1, 8'hA7, 0, 0, 1, 8'hA7, 1, 0);   // bypass after reset
    add(0, 8'h00, 1, 0, 1, 8'hA7, 0, 0);   // empty + advance: valid drops, out held
    add(1, 8'h11, 0, 0, 1, 8'h11, 1, 0);
    add(1, 8'h22, 0, 0, 1, 8'h11, 1, 1);
    add(1, 8'h33, 0, 0, 1, 8'h11, 1, 2);
    add(1, 8'h44, 0, 0, 1, 8'h11, 1, 3);
    add(1, 8'h55, 0, 0, 1, 8'h11, 1, 4);
    add(1, 8'h66, 0, 0, 0, 8'h11, 1, 4);   // full: held off
    add(1, 8'h66, 0, 0, 0, 8'h11, 1, 4);
    add(0, 8'h00, 1, 0, 0, 8'h22, 1, 3);   // drain in order
    add(0, 8'h00, 1, 0, 1, 8'h33, 1, 2);
    add(0, 8'h00, 1, 0, 1, 8'h44, 1, 1);
    add(0, 8'h00, 1, 0, 1, 8'h55, 1, 0);
    add(0, 8'h00, 1, 0, 1, 8'h55, 0, 0);
    add(1, 8'h01, 0, 0, 1, 8'h01, 1, 0);   // stream 01..0C
    for (int k = 2; k <= 12; k++) add(1, 8'(k), 1, 0, 1, 8'(k), 1, 0);
    add(0, 8'h00, 1, 0, 1, 8'h0C, 0, 0);
    add(1, 8'hA1, 0, 0, 1, 8'hA1, 1, 0);
    add(1, 8'hB2, 0, 0, 1, 8'hA1, 1, 1);
    add(1, 8'hC3, 0, 0, 1, 8'hA1, 1, 2);
    add(1, 8'hD4, 0, 0, 1, 8'hA1, 1, 3);
    add(1, 8'h99, 0, 1, 0, 8'h00, 0, 0);   // flush wins over in_valid
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0);   // 0x99 not captured
    add(1, 8'h2C, 0, 0, 1, 8'h2C, 1, 0);   // immediate FC signed / 0C unsigned
    add(1, 8'h25, 1, 0, 1, 8'h25, 1, 0);   // immediate 05 both
    add(0, 8'h00, 1, 0, 1, 8'h25, 0, 0);

    // reset state
    cycle(1, 0, 8'h00, 0, 0, 0);
    chk("rst_ir_out", ir_out, 8'h00);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_count", 32'(count), 0);
    chk("rst_immediate", imm, 8'h00);
    chk("rst_immediate_signed", imm_s, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);

    foreach (vecs[i]) begin
      logic [7:0] o;
      cycle(0, vecs[i].iv, vecs[i].din, vecs[i].adv, vecs[i].fl, 0);
      o = vecs[i].out;
      chk($sformatf("vec%0d_in_ready", i), pre_rdy, vecs[i].rdy);
      chk($sformatf("vec%0d_ir_out", i), ir_out, o);
      chk($sformatf("vec%0d_ir_valid", i), ir_valid, vecs[i].vld);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_imm", i), imm, {4'h0, o[3:0]});
      chk($sformatf("vec%0d_imm_s", i), imm_s, {{4{o[3]}}, o[3:0]});
    end

    // full queue: a waiting word is only taken after an advance frees a slot
    for (int k = 0; k < 5; k++) cycle(0, 1, 8'h70 + 8'(k), 0, 0, 1);
    cycle(0, 1, 8'h66, 1, 0, 1);
    cycle(0, 1, 8'h66, 0, 0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 0, 8'h00, 1, 0, 1);

    // reset mid-operation discards everything
    for (int k = 0; k < 3; k++) cycle(0, 1, 8'hE0 + 8'(k), 0, 0, 1);
    cycle(1, 1, 8'hEE, 1, 0, 1);
    cycle(0, 0, 8'h00, 1, 0, 1);

    // randomized traffic with phases of varying advance rate
    for (int n = 0; n < 600; n++) begin
      logic r, iv, a, f;
      int adv_pct;
      adv_pct = ((n / 60) % 3 == 0) ? 20 : (((n / 60) % 3 == 1) ? 50 : 90);
      r  = ($urandom_range(0, 149) == 0);
      f  = ($urandom_range(0, 39) == 0);
      iv = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 99) < adv_pct);
      cycle(r, iv, 8'($urandom), a, f, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
